// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [5:0]  req_funct;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        slot_en;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    modport master(
        output req_valid, req_op, req_funct, req_rs, req_rt, req_rd, req_imm, req_target, slot_en,
        input  req_ready, wr_en, wr_addr, wr_data
    );
    modport slave(
        input  req_valid, req_op, req_funct, req_rs, req_rt, req_rd, req_imm, req_target, slot_en,
        output req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-style requests into words written sequentially to instruction memory.
module instr_encoder #(
    parameter int MEM_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_base,
    input  logic [31:0]           base_addr,
    output logic [15:0]           count,
    output logic                  full,
    output logic                  err_op,
    instr_encoder_if.slave        bus
);
    typedef enum logic {IDLE, SLOT} state_t;
    localparam logic [15:0] LIMIT = 16'(MEM_WORDS);
    localparam logic [15:0] LAST  = 16'(MEM_WORDS - 1);
    state_t      state;
    logic [31:0] ptr;
    logic [31:0] enc;
    logic        is_br;
    logic        accept;
    assign is_br = bus.req_op == 3'd3 || bus.req_op == 3'd5 || bus.req_op == 3'd6;
    assign full  = count == LIMIT;
    // A branch needing a delay slot is held off unless both words fit.
    assign bus.req_ready = rst && state == IDLE && !full && !load_base
                           && !(bus.slot_en && is_br && count == LAST);
    assign accept = bus.req_valid && bus.req_ready;
    always_comb begin
        enc = bus.req_op == 3'd0 ? {6'd0, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, bus.req_funct} :
              bus.req_op == 3'd1 ? {6'd35, bus.req_rs, bus.req_rt, bus.req_imm} :
              bus.req_op == 3'd2 ? {6'd43, bus.req_rs, bus.req_rt, bus.req_imm} :
              bus.req_op == 3'd3 ? {6'd4, bus.req_rs, bus.req_rt, bus.req_imm} :
              bus.req_op == 3'd4 ? {6'd9, bus.req_rs, bus.req_rt, bus.req_imm} :
              bus.req_op == 3'd5 ? {6'd2, bus.req_target} :
              bus.req_op == 3'd6 ? {6'd3, bus.req_target} : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= 32'd0;
            count       <= 16'd0;
            err_op      <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= 32'd0;
            bus.wr_data <= 32'd0;
        end else begin
            bus.wr_en <= 1'b0;
            if (state == SLOT) begin
                bus.wr_en   <= 1'b1;
                bus.wr_addr <= ptr;
                bus.wr_data <= 32'd0;
                ptr         <= ptr + 32'd4;
                count       <= count + 16'd1;
                state       <= IDLE;
            end else if (load_base) begin
                ptr   <= base_addr & ~32'd3;
                count <= 16'd0;
            end else if (accept) begin
                if (bus.req_op == 3'd7) begin
                    err_op <= 1'b1;
                end else begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= ptr;
                    bus.wr_data <= enc;
                    ptr         <= ptr + 32'd4;
                    count       <= count + 16'd1;
                    state       <= bus.slot_en && is_br ? SLOT : IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random stimulus checked against a word-level memory-writer model.
module tb_instr_encoder;
    localparam int MW = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_base = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [15:0] count;
    logic        full;
    logic        err_op;
    int          checks = 0;
    int          errors = 0;
    instr_encoder_if bus();
    instr_encoder #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .load_base(load_base), .base_addr(base_addr),
        .count(count), .full(full), .err_op(err_op), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    int          m_cnt = 0;
    bit [31:0]   m_ptr = 0, m_waddr = 0, m_wdata = 0;
    bit          m_err = 0, m_pend = 0, m_wen = 0;
    int          opc[8] = '{0, 35, 43, 4, 9, 2, 3, 0};
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic bit [31:0] encode();
        bit [5:0] o = 6'(opc[bus.req_op]);
        case (bus.req_op)
            3'd0: return {o, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, bus.req_funct};
            3'd5, 3'd6: return {o, bus.req_target};
            3'd7: return 32'd0;
            default: return {o, bus.req_rs, bus.req_rt, bus.req_imm};
        endcase
    endfunction
    function automatic void mwrite(bit [31:0] w);
        m_wen = 1; m_waddr = m_ptr; m_wdata = w; m_ptr += 4; m_cnt++;
    endfunction
    task automatic tick();
        bit br, rdy;
        @(negedge clk);
        br  = bus.req_op inside {3'd3, 3'd5, 3'd6};
        rdy = rst && !m_pend && m_cnt != MW && !load_base && !(bus.slot_en && br && MW - m_cnt == 1);
        check("req_ready", bus.req_ready, rdy);
        m_wen = 0;
        if (!rst) begin
            m_cnt = 0; m_ptr = 0; m_waddr = 0; m_wdata = 0; m_err = 0; m_pend = 0;
        end else if (m_pend) begin
            mwrite(32'd0); m_pend = 0;
        end else if (load_base) begin
            m_ptr = {base_addr[31:2], 2'b00}; m_cnt = 0;
        end else if (bus.req_valid && rdy) begin
            if (bus.req_op == 3'd7) m_err = 1;
            else begin
                mwrite(encode());
                m_pend = bus.slot_en && br;
            end
        end
        @(posedge clk);
        #1;
        check("wr_en", bus.wr_en, m_wen);
        check("wr_addr", bus.wr_addr, m_waddr);
        check("wr_data", bus.wr_data, m_wdata);
        check("count", count, 32'(m_cnt));
        check("full", full, m_cnt == MW);
        check("err_op", err_op, m_err);
    endtask
    task automatic req(input bit [2:0] op, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                       input bit [5:0] funct, input bit [15:0] imm, input bit [25:0] target);
        bus.req_valid = 1; bus.req_op = op; bus.req_rs = rs; bus.req_rt = rt; bus.req_rd = rd;
        bus.req_funct = funct; bus.req_imm = imm; bus.req_target = target;
    endtask
    task automatic do_reset();
        rst = 0; bus.req_valid = 0; load_base = 0; bus.slot_en = 0;
        tick();
        rst = 1;
    endtask
    initial begin
        bus.req_valid = 0; bus.slot_en = 0;
        req(3'd0, 0, 0, 0, 0, 0, 0); bus.req_valid = 0;
        rst = 0;
        tick();
        tick();
        check("reset_ready", bus.req_ready, 1'b0);
        rst = 1;
        req(3'd0, 5'd1, 5'd2, 5'd3, 6'h21, 16'd0, 26'd0);
        tick();
        check("rtype_word", bus.wr_data, 32'h0022_1821);
        check("rtype_addr", bus.wr_addr, 32'd0);
        bus.req_valid = 0;
        tick();
        do_reset();
        bus.slot_en = 1;
        req(3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFE, 26'd0);
        tick();
        check("beq_word", bus.wr_data, 32'h1085_FFFE);
        bus.slot_en = 0;
        tick();
        check("nop_addr", bus.wr_addr, 32'd4);
        check("slot_count", count, 32'd2);
        bus.req_valid = 0;
        tick();
        load_base = 1; base_addr = 32'h0000_0103;
        tick();
        load_base = 0;
        req(3'd6, 0, 0, 0, 0, 0, 26'h0000040);
        tick();
        check("jal_addr", bus.wr_addr, 32'h0000_0100);
        check("jal_word", bus.wr_data, 32'h0C00_0040);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req(3'd4, 5'(i), 5'(i + 1), 0, 0, 16'(i * 7), 0);
            tick();
        end
        bus.slot_en = 1;
        req(3'd5, 0, 0, 0, 0, 0, 26'h123);
        tick();
        check("j_blocked", bus.wr_en, 1'b0);
        req(3'd1, 5'd0, 5'd8, 0, 0, 16'd4, 0);
        tick();
        check("lw_word", bus.wr_data, 32'h8C08_0004);
        check("lw_full", full, 1'b1);
        tick();
        tick();
        do_reset();
        req(3'd7, 0, 0, 0, 0, 0, 0);
        tick();
        check("op7_err", err_op, 1'b1);
        req(3'd2, 5'd29, 5'd31, 0, 0, 16'd8, 0);
        tick();
        check("sw_word", bus.wr_data, 32'hAFBF_0008);
        check("sw_addr", bus.wr_addr, 32'd0);
        do_reset();
        bus.slot_en = 1;
        req(3'd5, 0, 0, 0, 0, 0, 26'h3FFFFFF);
        tick();
        bus.req_valid = 0;
        rst = 0;
        tick();
        rst = 1;
        tick();
        check("post_reset_ready", bus.req_ready, 1'b1);
        for (int i = 0; i < 400; i++) begin
            rst = $urandom_range(39) != 0;
            load_base = $urandom_range(7) == 0;
            base_addr = $urandom;
            bus.slot_en = $urandom_range(1);
            req(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                16'($urandom), 26'($urandom));
            bus.req_valid = $urandom_range(3) != 0;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
